// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES permutation tables, S-box contents, key rotation schedule and FSM states
// Purpose: shared constants and bit-permutation helpers for the DES decryption core.
// All tables use DES numbering: entry value n selects DES bit n, bit 1 being the MSB.
package des_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Right-rotation of C,D taken before deriving the subkey of round cnt.
   // Round 0 uses the PC1 value unrotated (K16 == left rotation by 28).
   localparam int RSHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // SBOX[n][row*16 + col] is the output of S-box n+1.
   localparam int SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_e(input logic [31:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
      return y;
   endfunction

   // Parity bits 8,16,..,64 never appear in PC1_T, so they drop out here.
   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      case (n)
         1:       return {x[0], x[27:1]};
         2:       return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_f.sv
// rtl/des_f.sv - combinational DES round function f(R,K)
// Purpose: E-expand R, xor subkey, substitute through S1..S8, permute with P.
// Ports: r_i - 32-bit right half, k_i - 48-bit subkey, f_o - 32-bit result.
module des_f
   import des_pkg::*;
(
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] f_o
);

   logic [47:0] x;
   logic [31:0] s;

   assign x = perm_e(r_i) ^ k_i;

   S1_BOX u_s1 (.b_i(x[47:42]), .s_o(s[31:28]));
   S2_BOX u_s2 (.b_i(x[41:36]), .s_o(s[27:24]));
   S3_BOX u_s3 (.b_i(x[35:30]), .s_o(s[23:20]));
   S4_BOX u_s4 (.b_i(x[29:24]), .s_o(s[19:16]));
   S5_BOX u_s5 (.b_i(x[23:18]), .s_o(s[15:12]));
   S6_BOX u_s6 (.b_i(x[17:12]), .s_o(s[11:8]));
   S7_BOX u_s7 (.b_i(x[11:6]),  .s_o(s[7:4]));
   S8_BOX u_s8 (.b_i(x[5:0]),   .s_o(s[3:0]));

   assign f_o = perm_p(s);

endmodule

// File: rtl/des_sbox.sv
// rtl/des_sbox.sv - DES S-boxes S1_BOX..S8_BOX
// Purpose: 6-bit to 4-bit substitution; row = {b5,b0}, column = b4:b1.
// Ports: b_i - 6-bit input group, s_o - 4-bit substituted output.
module S1_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[0][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S2_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[1][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S3_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[2][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S4_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[3][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S5_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[4][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S6_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[5][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S7_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[6][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module S8_BOX import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
   assign s_o = 4'(SBOX[7][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decryption, one Feistel round per clock
// Purpose: accept ciphertext+key, run ROUNDS rounds with a reverse key schedule, return plaintext.
// Ports: clk, rst_n (async, active-low);
//        in_valid/in_ready/in_cipher/in_key  - input handshake (bit 63 = DES bit 1);
//        out_valid/out_ready/out_plain       - registered plaintext handshake;
//        busy                                - high while in ROUND or DONE.
module des_decrypt_core
   import des_pkg::*;
#(
   parameter int ROUNDS = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_cipher,
   input  logic [63:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_plain,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] l_q, l_d, r_q, r_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic [63:0] plain_q, plain_d;
   logic        valid_q, valid_d;

   logic [63:0] lr_ip;
   logic [55:0] cd_pc1;
   logic [27:0] c_rot, d_rot;
   logic [47:0] subkey;
   logic [31:0] f_out;
   logic [31:0] r_next;

   assign lr_ip  = perm_ip(in_cipher);
   assign cd_pc1 = perm_pc1(in_key);

   // Decryption walks the schedule backwards: each round rotates C,D right,
   // and the rotated value is both used for this subkey and stored.
   assign c_rot  = rotr28(c_q, RSHIFT[cnt_q]);
   assign d_rot  = rotr28(d_q, RSHIFT[cnt_q]);
   assign subkey = perm_pc2({c_rot, d_rot});

   des_f u_f (
      .r_i (r_q),
      .k_i (subkey),
      .f_o (f_out)
   );

   assign r_next = l_q ^ f_out;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      plain_d = plain_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               {l_d, r_d} = lr_ip;
               {c_d, d_d} = cd_pc1;
               cnt_d      = 4'd0;
               state_d    = ROUND;
            end
         end
         ROUND: begin
            l_d   = r_q;
            r_d   = r_next;
            c_d   = c_rot;
            d_d   = d_rot;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(ROUNDS - 1)) begin
               // Final swap: output block is {R16, L16}.
               plain_d = perm_fp({r_next, r_q});
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         l_q     <= 32'd0;
         r_q     <= 32'd0;
         c_q     <= 28'd0;
         d_q     <= 28'd0;
         plain_q <= 64'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         plain_q <= plain_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_plain = plain_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - self-checking bench for des_decrypt_core
module tb_des_decrypt_core;
   import des_pkg::*;

   localparam int NRAND = 1000;
   localparam int LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_cipher;
   logic [63:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_plain;
   logic        busy;

   int checks;
   int failures;
   int n_rx;
   logic [63:0] exp_q [$];

   typedef struct {
      logic [63:0] key;
      logic [63:0] cipher;
      logic [63:0] plain;
   } kat_t;

   kat_t kats [3];

   des_decrypt_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cipher (in_cipher),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_plain (out_plain),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference DES: forward key schedule with left shifts, whole-block arithmetic.
   function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      int b, row, col;
      x = perm_e(r) ^ k;
      s = 32'd0;
      for (int g = 0; g < 8; g++) begin
         b   = int'(x[47-6*g -: 6]);
         row = ((b >> 4) & 2) | (b & 1);
         col = (b >> 1) & 15;
         s   = (s << 4) | 32'(SBOX[g][row*16 + col]);
      end
      return perm_p(s);
   endfunction

   function automatic logic [63:0] m_des(input logic [63:0] key, input logic [63:0] blk, input bit dec);
      logic [47:0] ks [16];
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [63:0] lr;
      logic [31:0] l, r, t;
      cd = perm_pc1(key);
      c  = cd[55:28];
      d  = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         for (int s = 0; s < LSHIFT[i]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         ks[i] = perm_pc2({c, d});
      end
      lr = perm_ip(blk);
      l  = lr[63:32];
      r  = lr[31:0];
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ m_f(r, ks[dec ? 15 - i : i]);
         l = t;
      end
      return perm_fp({r, l});
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge where out_valid is first seen.
   task automatic run_block(input logic [63:0] key, input logic [63:0] ct,
                            output logic [63:0] pt, output int lat, output bit ctl_ok);
      in_key    = key;
      in_cipher = ct;
      in_valid  = 1'b1;
      lat       = 0;
      ctl_ok    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
         if (!busy || in_ready) ctl_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!busy || in_ready) ctl_ok = 1'b0;
      pt = out_plain;
   endtask

   initial begin
      logic [63:0] pt;
      int          lat;
      bit          ok;

      checks    = 0;
      failures  = 0;
      n_rx      = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_cipher = 64'd0;
      in_key    = 64'd0;
      out_ready = 1'b0;

      kats[0] = '{key: 64'h133457799BBCDFF1, cipher: 64'h85E813540F0AB405, plain: 64'h0123456789ABCDEF};
      kats[1] = '{key: 64'h0E329232EA6D0D73, cipher: 64'h0000000000000000, plain: 64'h8787878787878787};
      kats[2] = '{key: 64'h0E329232EA6D0D73 ^ 64'h0101010101010101,
                  cipher: 64'h0000000000000000, plain: 64'h8787878787878787};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_plain", out_plain, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_busy", 64'(busy), 64'd0);

      // Known-answer table
      for (int i = 0; i < 3; i++) begin
         run_block(kats[i].key, kats[i].cipher, pt, lat, ok);
         chk($sformatf("kat%0d_plain", i), pt, kats[i].plain);
         chk($sformatf("kat%0d_latency", i), 64'(lat), 64'd16);
         chk($sformatf("kat%0d_ctl", i), 64'(ok), 64'd1);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("kat%0d_valid_drop", i), 64'(out_valid), 64'd0);
         chk($sformatf("kat%0d_idle_ready", i), 64'(in_ready), 64'd1);
      end

      // Backpressure: hold out_ready low 5 cycles, pulse in_valid during DONE
      run_block(kats[0].key, kats[0].cipher, pt, lat, ok);
      chk("hold_first_plain", pt, kats[0].plain);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            in_key    = kats[1].key;
            in_cipher = kats[1].cipher;
            in_valid  = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk("hold_plain", out_plain, kats[0].plain);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("release_busy", 64'(busy), 64'd0);
      run_block(kats[1].key, kats[1].cipher, pt, lat, ok);
      chk("b2b_plain", pt, kats[1].plain);
      chk("b2b_latency", 64'(lat), 64'd16);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset during round 7
      in_key    = kats[0].key;
      in_cipher = kats[0].cipher;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_abort_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_plain", out_plain, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_block(kats[2].key, kats[2].cipher, pt, lat, ok);
      chk("after_abort_plain", pt, kats[2].plain);
      chk("after_abort_latency", 64'(lat), 64'd16);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Randomized, throttled traffic against the reference model
      fork
         begin
            logic [63:0] k, p;
            int          w;
            for (int i = 0; i < NRAND; i++) begin
               k = {$urandom(), $urandom()};
               p = {$urandom(), $urandom()};
               exp_q.push_back(p);
               repeat ($urandom_range(0, 3)) @(negedge clk);
               in_key    = k;
               in_cipher = m_des(k, p, 1'b0);
               in_valid  = 1'b1;
               w = 0;
               while (!in_ready && w < 200) begin
                  @(negedge clk);
                  w++;
               end
               if (w >= 200) begin
                  checks++;
                  failures++;
                  $display("FAIL rand_accept_timeout: block %0d not accepted within %0d cycles", i, w);
                  in_valid = 1'b0;
                  break;
               end
               @(negedge clk);
               in_valid = 1'b0;
            end
         end
         begin
            int idle;
            idle = 0;
            while (n_rx < NRAND && idle < 400) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL rand_extra_block: got %h expected none", out_plain);
                  end else begin
                     chk("rand_plain", out_plain, exp_q.pop_front());
                  end
                  n_rx++;
                  idle = 0;
               end else begin
                  idle++;
               end
            end
         end
      join
      chk("rand_count", 64'(n_rx), 64'(NRAND));
      out_ready = 1'b1;
      begin
         int extra;
         extra = 0;
         repeat (40) begin
            @(negedge clk);
            if (out_valid) extra++;
         end
         chk("rand_no_duplicates", 64'(extra), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
